// File: rtl/param_counter.sv
// Up/down modulo counter with configurable width, modulus and step, plus a terminal-count pulse
// and a sticky overflow flag. Define PARAM_COUNTER_SATURATE_EN to clamp at 0/MAX instead of wrapping.
module param_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX       = 2**WIDTH - 1,
  parameter int unsigned STEP      = 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] value_o,
  output logic             tc_o,
  output logic             ovf_o
);

  // All arithmetic is carried at WIDTH+1 bits so value+STEP can never silently truncate.
  localparam logic [WIDTH:0]   MaxW  = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   StepW = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MaxV  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] StepV = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RstV  = WIDTH'(RESET_VAL);
`ifndef PARAM_COUNTER_SATURATE_EN
  localparam logic [WIDTH:0]   ModW  = MaxW + 1'b1;
`endif

  logic [WIDTH-1:0] value_q, value_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum_up;

  assign sum_up = {1'b0, value_q} + StepW;

  always_comb begin
    value_d = value_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr_i) begin
      value_d = RstV;
      ovf_d   = 1'b0;
    end else if (load_i) begin
      value_d = ({1'b0, load_val_i} > MaxW) ? MaxV : load_val_i;
    end else if (en_i) begin
      if (up_i) begin
        if (sum_up <= MaxW) begin
          value_d = sum_up[WIDTH-1:0];
        end else begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
`ifdef PARAM_COUNTER_SATURATE_EN
          value_d = MaxV;
`else
          value_d = WIDTH'(sum_up - ModW);
`endif
        end
      end else begin
        if ({1'b0, value_q} >= StepW) begin
          value_d = value_q - StepV;
        end else begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
`ifdef PARAM_COUNTER_SATURATE_EN
          value_d = '0;
`else
          // MAX+1 > STEP, so this stays positive and below MAX+1.
          value_d = WIDTH'({1'b0, value_q} + ModW - StepW);
`endif
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= RstV;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value_o = value_q;
  assign tc_o    = tc_q;
  assign ovf_o   = ovf_q;

endmodule

// File: doc/param_counter.md
Name: param_counter

Overview:
Parametrised successor to the team's fixed 8-bit counter. It is an up/down modulo counter with configurable width, modulus and step. It adds enable, synchronous clear and parallel load, plus a terminal-count pulse and a sticky overflow flag. It is a general-purpose timebase and event counter for datapath and test blocks.

Parameters:
WIDTH, 8, bit width of value and load_val (>=2).
MAX, 2**WIDTH-1, highest legal count; the counter is modulo MAX+1 (1 <= MAX <= 2**WIDTH-1).
STEP, 1, increment/decrement per enabled cycle (1 <= STEP <= MAX).
RESET_VAL, 0, value after reset and after clr (must be <= MAX).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
en  in  1  count enable; when high, value advances by STEP
up  in  1  direction: 1 = count up, 0 = count down
clr  in  1  synchronous clear to RESET_VAL
load  in  1  synchronous parallel load
load_val  in  WIDTH  value to load
value  out  WIDTH  registered count
tc  out  1  registered terminal-count pulse
ovf  out  1  registered sticky overflow/underflow flag

Behaviour:
- Reset (reset=0), asynchronous and immediate:
  - value=RESET_VAL, tc=0, ovf=0.
  - Held for as long as reset=0; counting resumes on the first rising edge after release.
- All other updates occur on the rising clk edge. Priority per edge is clr > load > en; a lower-priority input is ignored when a higher one is active.
- clr: value=RESET_VAL, tc=0, ovf=0.
- load:
  - value = min(load_val, MAX); tc=0; ovf unchanged.
- en=1, up=1:
  - If value+STEP <= MAX: value += STEP.
  - Otherwise (wrap): value = value+STEP-(MAX+1).
  - Sum is computed at WIDTH+1 bits, so there is no silent truncation.
- en=1, up=0:
  - If value >= STEP: value -= STEP.
  - Otherwise (wrap): value = value+(MAX+1)-STEP.
- en=0 with no clr/load: value holds; tc=0.
- tc:
  - High for exactly one cycle, coincident with the post-wrap value.
  - Low on every cycle with no wrap; back-to-back wraps give consecutive high cycles.
- ovf: set on any wrap (either direction); cleared only by clr or reset.
- Direction change (up toggled) takes effect on the same edge; no pipeline, latency 1 cycle from en to value.
- reset asserted mid-count: outputs clear immediately, not waiting for clk.
- value never exceeds MAX under any input sequence.

Optional Feature:
PARAM_COUNTER_SATURATE_EN
- Defined:
  - Counting up past MAX holds value=MAX; counting down below 0 holds value=0.
  - tc pulses (and ovf sets) on every enabled cycle where clamping occurs, including while parked at the limit.
- Undefined: modulo wrap as described above.
- clr and load priority and semantics are identical in both builds.

Test Plan:
1. WIDTH=4, MAX=9, STEP=1, up=1, en=1 from reset, 10 edges -> value 1..9 then 0; tc=1 only with value=0; ovf=1 afterwards.
2. MAX=9, STEP=3, load_val=8, then en=1 up=1 one edge -> value=1, tc=1; then up=0 en=1 one edge -> value=8 (1+10-3), tc=1.
3. Count to 5, drop reset to 0 at mid-cycle (not on an edge) -> value=0, tc=0, ovf=0 immediately; hold 2 cycles; release -> counts 1,2,...
4. Same edge clr=1, load=1 (load_val=7), en=1 with ovf=1 -> value=RESET_VAL(0), ovf=0. Next edge load=1 with load_val=12, MAX=9 -> value=9.
5. en=0 for 5 edges at value=4, up toggling each edge -> value stays 4, tc=0.
6. With PARAM_COUNTER_SATURATE_EN, MAX=9, STEP=3, value=8, en=1 up=1 two edges -> value 9, 9; tc=1 both cycles; ovf=1. Without the macro the same stimulus -> value 1, 4.
